// File: rtl/scan_chain_ctrl_if.sv
// Handshake and chain-control bundle between a requester/chain and scan_chain_ctrl.
// The master side drives the request and the chain's serial output; the slave is the controller.
interface scan_chain_ctrl_if #(
  parameter int LEN = 4
);
  logic           START;
  logic           INIT;
  logic [LEN-1:0] PI;
  logic [LEN-1:0] EXP;
  logic           SO;
  logic           SI;
  logic           SE;
  logic           CE;
  logic           SNO;
  logic           BUSY;
  logic           DONE;
  logic [LEN-1:0] PO;
  logic           PASS;

  modport master (
    output START, INIT, PI, EXP, SO,
    input  SI, SE, CE, SNO, BUSY, DONE, PO, PASS
  );

  modport slave (
    input  START, INIT, PI, EXP, SO,
    output SI, SE, CE, SNO, BUSY, DONE, PO, PASS
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Load / optional preset / capture / unload sequencer for a LEN-stage mux-scan set-flop chain,
// comparing the unloaded word against an expected value behind a single start/done handshake.
module scan_chain_ctrl #(
  parameter int LEN = 4
) (
  input  logic             CK,
  input  logic             RN,
  scan_chain_ctrl_if.slave bus
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESET,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [LEN-1:0] pi_q;
  logic [LEN-1:0] exp_q;
  logic [LEN-1:0] po_q;
  logic           pass_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: a default for every comb-assigned signal up front keeps incomplete
    // case branches from inferring latches.
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (bus.START) begin
          state_next = bus.INIT ? S_PRESET : S_SHIFT_IN;
        end
      end
      S_PRESET:    state_next = S_SHIFT_IN;
      S_SHIFT_IN:  if (cnt == LAST) state_next = S_CAPTURE;
      S_CAPTURE:   state_next = S_SHIFT_OUT;
      S_SHIFT_OUT: if (cnt == LAST) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Counter restarts at 0 on every state change, so it never needs to wrap.
  always_ff @(posedge CK) begin
    if (!RN) begin
      cnt    <= '0;
      pi_q   <= '0;
      exp_q  <= '0;
      po_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      if (state != state_next) begin
        cnt <= '0;
      end else if (state == S_SHIFT_IN || state == S_SHIFT_OUT) begin
        cnt <= cnt + CW'(1);
      end

      if (state == S_IDLE && bus.START) begin
        pi_q   <= bus.PI;
        exp_q  <= bus.EXP;
        po_q   <= '0;
        pass_q <= 1'b0;
      end

      // The last unload bit lands in PO[0]; fold it into the compare so PASS is
      // already valid in the DONE cycle.
      if (state == S_SHIFT_OUT) begin
        po_q[LAST - cnt] <= bus.SO;
        if (cnt == LAST) begin
          pass_q <= ({po_q[LEN-1:1], bus.SO} == exp_q);
        end
      end
    end
  end

  always_comb begin
    bus.SI   = 1'b0;
    bus.SE   = 1'b0;
    bus.CE   = 1'b0;
    bus.SNO  = 1'b1;
    bus.BUSY = 1'b0;
    bus.DONE = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_PRESET: begin
        bus.SNO  = 1'b0;
        bus.BUSY = 1'b1;
      end
      S_SHIFT_IN: begin
        bus.SI   = pi_q[LAST - cnt];
        bus.SE   = 1'b1;
        bus.CE   = 1'b1;
        bus.BUSY = 1'b1;
      end
      S_CAPTURE: begin
        bus.CE   = 1'b1;
        bus.BUSY = 1'b1;
      end
      S_SHIFT_OUT: begin
        bus.SE   = 1'b1;
        bus.CE   = 1'b1;
        bus.BUSY = 1'b1;
      end
      S_DONE: begin
        bus.BUSY = 1'b1;
        bus.DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PO   = po_q;
  assign bus.PASS = pass_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: drives a behavioural 4-flop mux-scan set-flop chain and checks
// every cycle of each run against a cycle-window model of the load/capture/unload sequence.
module tb_scan_chain_ctrl;

  localparam int LEN = 4;

  logic CK = 1'b0;
  logic RN = 1'b0;

  scan_chain_ctrl_if #(.LEN(LEN)) bus ();

  scan_chain_ctrl #(.LEN(LEN)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  // Behavioural chain: stage 0 takes SI, SO is stage LEN-1, FD feeds the functional inputs.
  logic [LEN-1:0] fd    = '0;
  logic [LEN-1:0] chain = '0;
  logic [LEN-1:0] fd_s  = '0;
  logic           se_s  = 1'b0;
  logic           ce_s  = 1'b0;
  logic           si_s  = 1'b0;
  logic           sno_s = 1'b1;

  always @(negedge CK) begin
    se_s  = bus.SE;
    ce_s  = bus.CE;
    si_s  = bus.SI;
    sno_s = bus.SNO;
    fd_s  = fd;
  end

  always @(posedge CK) begin
    if (!sno_s)     chain <= '1;
    else if (ce_s)  chain <= se_s ? {chain[LEN-2:0], si_s} : fd_s;
  end

  assign bus.SO = chain[LEN-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected {SNO,SE,CE,BUSY,DONE,SI} in cycle c after accept (accept edge ends cycle 0).
  function automatic logic [5:0] exp_ctl(input int c, input int off, input logic [LEN-1:0] pi);
    if (off == 1 && c == 1)             return 6'b000100;
    if (c >= off + 1 && c <= off + LEN) return {5'b11110, pi[LEN-1-(c-off-1)]};
    if (c == off + LEN + 1)             return 6'b101100;
    if (c <= off + 2*LEN + 1)           return 6'b111100;
    if (c == off + 2*LEN + 2)           return 6'b100110;
    return 6'b100000;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {bus.SNO, bus.SE, bus.CE, bus.BUSY, bus.DONE, bus.SI};
  endfunction

  task automatic run(input logic [LEN-1:0] pi, input logic [LEN-1:0] exp,
                     input logic [LEN-1:0] fd_v, input logic init,
                     input bit hold, input bit wait_idle, input int rst_at,
                     input int pulse_a, input int pulse_b);
    int off;
    int done_c;
    int last_c;
    off    = init ? 1 : 0;
    done_c = 2*LEN + 2 + off;
    last_c = hold ? done_c : done_c + 1;
    bus.START = 1'b1;
    bus.PI    = pi;
    bus.EXP   = exp;
    bus.INIT  = init;
    fd        = init ? 'x : fd_v;
    if (wait_idle) begin
      @(posedge CK);
      @(negedge CK);
      check("idle_gap_busy", bus.BUSY, 1'b0);
    end
    @(posedge CK);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge CK);
      check($sformatf("ctl c%0d", c), ctl_now(), exp_ctl(c, off, pi));
      if (init && c == 2)       check("chain_after_preset", chain, {LEN{1'b1}});
      if (c == off + LEN + 1)   check("chain_after_shift_in", chain, pi);
      if (c == done_c) begin
        check("po_at_done", bus.PO, fd_v);
        check("pass_at_done", bus.PASS, fd_v == exp);
      end
      if (c == done_c + 1) begin
        check("po_hold", bus.PO, fd_v);
        check("pass_hold", bus.PASS, fd_v == exp);
      end
      if (c == rst_at) begin
        RN = 1'b0;
        bus.START = 1'b0;
        @(negedge CK);
        RN = 1'b1;
        check("midrun_rst_ctl", ctl_now(), 6'b100000);
        check("midrun_rst_po", bus.PO, 0);
        check("midrun_rst_pass", bus.PASS, 0);
        return;
      end
      if (c == 1) begin
        fd       = fd_v;
        bus.PI   = LEN'($urandom);
        bus.EXP  = LEN'($urandom);
        bus.INIT = 1'($urandom);
      end
      bus.START = hold || c == pulse_a || c == pulse_b;
      if (c == pulse_a || c == pulse_b) bus.PI = '1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LEN-1:0] r_pi, r_fd, r_exp;
    bus.START = 1'b0;
    bus.INIT  = 1'b0;
    bus.PI    = '0;
    bus.EXP   = '0;
    RN = 1'b0;
    repeat (2) @(posedge CK);
    @(negedge CK);
    check("por_ctl", ctl_now(), 6'b100000);
    check("por_po", bus.PO, 0);
    check("por_pass", bus.PASS, 0);
    RN = 1'b1;

    // Basic matching run, then reset mid-idle must clear PO and PASS.
    run(4'b1010, 4'b0110, 4'b0110, 1'b0, 0, 0, 0, 0, 0);
    RN = 1'b0;
    repeat (2) @(posedge CK);
    @(negedge CK);
    check("idle_rst_ctl", ctl_now(), 6'b100000);
    check("idle_rst_po", bus.PO, 0);
    check("idle_rst_pass", bus.PASS, 0);
    RN = 1'b1;

    // Mismatch run.
    run(4'b1010, 4'b0111, 4'b0110, 1'b0, 0, 0, 0, 0, 0);
    // Preset run.
    run(4'b0000, 4'b1100, 4'b1100, 1'b1, 0, 0, 0, 0, 0);
    // START pulses while busy and during DONE are ignored.
    run(4'b1010, 4'b0110, 4'b0110, 1'b0, 0, 0, 0, 3, 10);
    // START held high: next run starts on the first IDLE cycle after DONE.
    run(4'b0101, 4'b1001, 4'b1001, 1'b0, 1, 0, 0, 0, 0);
    run(4'b1100, 4'b0011, 4'b0011, 1'b0, 0, 1, 0, 0, 0);
    // Reset during SHIFT_OUT j=1, then a clean run.
    run(4'b1010, 4'b1001, 4'b1001, 1'b0, 0, 0, LEN + 3, 0, 0);
    run(4'b0011, 4'b0101, 4'b0101, 1'b0, 0, 0, 0, 0, 0);

    repeat (12) begin
      r_pi  = LEN'($urandom);
      r_fd  = LEN'($urandom);
      r_exp = ($urandom_range(0, 1) == 1) ? r_fd : LEN'($urandom);
      run(r_pi, r_exp, r_fd, 1'($urandom), 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencer for a chain of LEN mux-scan flip-flops, each a D flop with active-low set plus a scan mux.
- Serially loads a parallel pattern, optionally presets the chain first, pulses one functional capture cycle, then shifts the chain contents out.
- Compares the unloaded word against an expected value.
- Used by the cell-level test benches to exercise flop chains through a single start/done handshake.

Parameters:
LEN, 4, number of flops in the controlled chain (minimum 2); the state counter is sized to hold LEN-1.

Ports:
CK     input   1    clock, rising-edge active
RN     input   1    synchronous active-low reset
START  input   1    request; accepted only in IDLE
INIT   input   1    sampled with START; 1 inserts a PRESET cycle
PI     input   LEN  pattern to shift in; sampled at accept
EXP    input   LEN  expected unload word; sampled at accept
SO     input   1    serial output of chain stage LEN-1
SI     output  1    serial input to chain stage 0
SE     output  1    scan enable: 1 selects shift path, 0 selects functional D
CE     output  1    chain clock enable
SNO    output  1    active-low set to all chain flops
BUSY   output  1    high from the cycle after accept through DONE
DONE   output  1    one-cycle completion pulse
PO     output  LEN  unloaded chain word
PASS   output  1    1 when PO equals the sampled EXP

Behaviour:
- The clock and reset are fixed: one clock, CK. Reset RN is synchronous and active-low.
- RN=0 at a CK edge forces IDLE and clears all internal registers. This applies in any state, including mid-operation.
- Reset output values: SI=0, SE=0, CE=0, SNO=1, BUSY=0, DONE=0, PO=0, PASS=0.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: if START=1, latch PI, EXP and INIT; clear PO and PASS; go to PRESET if INIT=1, else SHIFT_IN.
  - PRESET: 1 cycle. SNO=0, CE=0, SE=0, BUSY=1. Next state SHIFT_IN.
  - SHIFT_IN: LEN cycles, count k=0..LEN-1. SE=1, CE=1, SI=PI[LEN-1-k]. After the last cycle, chain stage i holds PI[i]. Next state CAPTURE.
  - CAPTURE: 1 cycle. SE=0, CE=1, SI=0. The chain loads its functional D inputs. Next state SHIFT_OUT.
  - SHIFT_OUT: LEN cycles, count j=0..LEN-1. SE=1, CE=1, SI=0. PO[LEN-1-j] is loaded from SO at the edge ending cycle j. Next state DONE.
  - DONE: 1 cycle. DONE=1, BUSY=1, CE=0, SE=0. PASS is registered as (PO==EXP_latched) on entry, so PASS is valid in the DONE cycle. Next state IDLE.
- Latency: with the accept edge as cycle 0, DONE is high in cycle 2*LEN+2 (INIT=0) or 2*LEN+3 (INIT=1).
- PO and PASS hold their values after DONE until the next accepted START.
- START while not in IDLE, including the DONE cycle, is ignored with no queuing. A request held high is accepted on the first IDLE cycle.
- PI, EXP and INIT changing after accept have no effect on the current run.
- SNO=1 in every state except PRESET. CE=0 in IDLE, PRESET and DONE.
- The k and j counters reset to 0 on entry to their state and wrap only by state exit. There is no arithmetic overflow.

Test Plan:
Bench setup: LEN=4, driving a behavioural chain of 4 mux-scan set-flops whose functional D inputs are driven by the bench as FD.
1. Reset: RN=0 for 2 edges mid-idle -> SI=0, SE=0, CE=0, SNO=1, BUSY=0, DONE=0, PO=4'b0000, PASS=0.
2. Basic run:
   - Stimulus: START=1 with PI=4'b1010, INIT=0, FD=4'b0110, EXP=4'b0110.
   - SI sequence during SHIFT_IN is 1,0,1,0; chain reads 4'b1010 after SHIFT_IN.
   - CAPTURE is a single cycle with SE=0.
   - DONE is high in cycle 10 only, with PO=4'b0110 and PASS=1.
3. Mismatch: same as scenario 2 but EXP=4'b0111 -> PO=4'b0110, PASS=0, DONE in cycle 10.
4. Preset run:
   - Stimulus: INIT=1, PI=4'b0000, FD driven to X during PRESET.
   - SNO=0 exactly in cycle 1; chain reads 4'b1111 after PRESET; chain reads 4'b0000 after SHIFT_IN.
   - DONE occurs in cycle 11.
5. Busy-window START: START pulses in cycles 3 and 10, with PI changed to 4'b1111 -> no restart and the current PO is unaffected. With START held high, the next run begins on the first IDLE cycle after DONE.
6. Mid-run reset:
   - Stimulus: RN=0 for one edge during SHIFT_OUT cycle j=1.
   - Next edge: all outputs at reset values, including BUSY=0 and PO=0.
   - A following START with PI=4'b0011, FD=4'b0101, EXP=4'b0101 completes normally with PASS=1.
